// File: rtl/sram_march_bist_ctrl.sv
// ---------------------------------------------------------------------------
// sram_march_bist_ctrl
// March C- BIST engine for the dedicated BIST port of a single-port SRAM
// macro. It issues one operation per clock through six march elements
// (w0 / r0,w1 / r1,w0 up, then r0,w1 / r1,w0 / r0 down). It also checks read
// data against the expected background, and it reports pass/fail, the first
// failing address and bits, and a saturating error count.
//
// Ports
//   A_BIST_CLK   : clock, shared with the macro BIST port
//   A_BIST_RST   : synchronous active-high reset
//   start        : level, sampled in IDLE/DONE, launches a run
//   A_DOUT       : macro read data
//   A_BIST_EN    : BIST port select (RUN and DRAIN)
//   A_BIST_MEN/WEN/REN/ADDR/DIN/BM : macro BIST command
//   busy / done  : run in progress / run finished
//   fail, fail_addr, fail_bits, err_cnt : compare results of the last run
// ---------------------------------------------------------------------------
module sram_march_bist_ctrl #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_RD_LAT     = 1
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST,
  input  logic                    start,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [P_DATA_WIDTH-1:0] fail_bits,
  output logic [7:0]              err_cnt
);

  localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_MAX = '1;
  localparam logic [P_DATA_WIDTH-1:0] L_D0       = '0;
  localparam logic [P_DATA_WIDTH-1:0] L_D1       = '1;
  localparam int                      L_PIPE     = P_RD_LAT + 1;
  localparam int                      L_DCNT_W   = $clog2(L_PIPE + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [2:0]              r_elem;   // march element M0..M5
  logic [P_ADDR_WIDTH-1:0] r_addr;
  logic                    r_phase;  // 0: first op at this address, 1: second
  logic [L_DCNT_W-1:0]     r_dcnt;

  // Compare pipeline: entry 0 is loaded with the command, and the last entry
  // lines up with the read data returned by the macro.
  logic                    r_vld_p  [L_PIPE];
  logic [P_ADDR_WIDTH-1:0] r_addr_p [L_PIPE];
  logic [P_DATA_WIDTH-1:0] r_exp_p  [L_PIPE];

  logic                    w_is_read;
  logic                    w_last_op;
  logic [P_ADDR_WIDTH-1:0] w_term;
  logic [P_DATA_WIDTH-1:0] w_rd_exp;
  logic [P_DATA_WIDTH-1:0] w_wr_dat;
  logic [2:0]              w_next_elem;
  logic [P_ADDR_WIDTH-1:0] w_next_start;
  logic [P_DATA_WIDTH-1:0] w_cmp_bits;
  logic                    w_mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // M0 and M5 have a single op per address; the others are read then write.
  assign w_is_read    = (r_elem == 3'd5) || ((r_elem != 3'd0) && !r_phase);
  assign w_last_op    = (r_elem == 3'd0) || (r_elem == 3'd5) || r_phase;
  assign w_term       = (r_elem <= 3'd2) ? L_ADDR_MAX : '0;
  assign w_rd_exp     = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? L_D1 : L_D0;
  assign w_wr_dat     = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? L_D1 : L_D0;
  assign w_next_elem  = r_elem + 3'd1;
  assign w_next_start = (w_next_elem <= 3'd2) ? '0 : L_ADDR_MAX;
  assign w_cmp_bits   = A_DOUT ^ r_exp_p[L_PIPE-1];
  assign w_mismatch   = r_vld_p[L_PIPE-1] && (w_cmp_bits != '0);

  // Pipeline address/expected payload needs no reset; only valid is flushed.
  always_ff @(posedge A_BIST_CLK) begin
    r_addr_p[0] <= r_addr;
    r_exp_p[0]  <= w_rd_exp;
    for (int i = 1; i < L_PIPE; i++) begin
      r_addr_p[i] <= r_addr_p[i-1];
      r_exp_p[i]  <= r_exp_p[i-1];
    end
  end

  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      r_state     <= S_IDLE;
      r_elem      <= '0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_dcnt      <= '0;
      for (int i = 0; i < L_PIPE; i++) r_vld_p[i] <= 1'b0;
      A_BIST_EN   <= 1'b0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      A_BIST_BM   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_bits   <= '0;
      err_cnt     <= '0;
    end else begin
      r_vld_p[0] <= 1'b0;
      for (int i = 1; i < L_PIPE; i++) r_vld_p[i] <= r_vld_p[i-1];

      // Compare stage: read data returned by the macro meets its expectation.
      if (w_mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= r_addr_p[L_PIPE-1];
          fail_bits <= w_cmp_bits;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_elem    <= '0;
            r_addr    <= '0;
            r_phase   <= 1'b0;
            A_BIST_EN <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_bits <= '0;
            err_cnt   <= '0;
          end
        end

        // Issue stage: one command per clock, entry 0 of the compare pipe.
        S_RUN: begin
          A_BIST_MEN  <= 1'b1;
          A_BIST_WEN  <= !w_is_read;
          A_BIST_REN  <= w_is_read;
          A_BIST_ADDR <= r_addr;
          A_BIST_BM   <= '1;
          if (!w_is_read) A_BIST_DIN <= w_wr_dat;
          r_vld_p[0]  <= w_is_read;

          if (!w_last_op) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_addr == w_term) begin
              if (r_elem == 3'd5) begin
                r_state <= S_DRAIN;
                r_dcnt  <= '0;
              end else begin
                r_elem <= w_next_elem;
                r_addr <= w_next_start;
              end
            end else if (r_elem <= 3'd2) begin
              r_addr <= r_addr + 1'b1;
            end else begin
              r_addr <= r_addr - 1'b1;
            end
          end
        end

        // Drain: keep the port selected until every read has been compared.
        S_DRAIN: begin
          A_BIST_MEN <= 1'b0;
          A_BIST_WEN <= 1'b0;
          A_BIST_REN <= 1'b0;
          A_BIST_BM  <= '0;
          r_dcnt     <= r_dcnt + L_DCNT_W'(1);
          if (r_dcnt == L_DCNT_W'(L_PIPE)) begin
            r_state   <= S_DONE;
            A_BIST_EN <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
module tb_sram_march_bist_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int NCMD  = 10 * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dout;
  logic          en, men, wen, ren, busy, done, fail;
  logic [AW-1:0] addr, fail_addr;
  logic [DW-1:0] din, bm, fail_bits;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_march_bist_ctrl #(
    .P_ADDR_WIDTH(AW),
    .P_DATA_WIDTH(DW),
    .P_RD_LAT(1)
  ) dut (
    .A_BIST_CLK (clk),
    .A_BIST_RST (rst),
    .start      (start),
    .A_DOUT     (dout),
    .A_BIST_EN  (en),
    .A_BIST_MEN (men),
    .A_BIST_WEN (wen),
    .A_BIST_REN (ren),
    .A_BIST_ADDR(addr),
    .A_BIST_DIN (din),
    .A_BIST_BM  (bm),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_bits  (fail_bits),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM model with fault injection (read latency 1) -------
  int            f_type = 0;  // 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 invert all reads
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_mask = '0;
  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] fault_rd(input logic [AW-1:0] a, input logic [DW-1:0] v);
    case (f_type)
      1:       return (a == f_addr) ? (v | f_mask) : v;
      2:       return (a == f_addr) ? (v & ~f_mask) : v;
      3:       return ~v;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (men && wen) mem[addr] <= din;
    if (men && ren) dout <= fault_rd(addr, mem[addr]);
  end

  // ---------------- Reference model: March C- command list and results -----
  // op codes: 0=w0 1=w1 2=r0 3=r1
  int elem_n   [6]    = '{1, 2, 2, 2, 2, 1};
  int elem_ops [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 2}};

  bit            exp_we   [NCMD];
  logic [AW-1:0] exp_addr [NCMD];
  logic [DW-1:0] exp_din  [NCMD];
  bit            m_fail;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_bits;
  int            m_cnt;

  task automatic build_model();
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] val, obs;
    int idx = 0;
    int a;
    int op;
    m_fail = 0; m_addr = '0; m_bits = '0; m_cnt = 0;
    for (int e = 0; e < 6; e++)
      for (int j = 0; j < DEPTH; j++) begin
        a = (e <= 2) ? j : DEPTH - 1 - j;
        for (int k = 0; k < elem_n[e]; k++) begin
          op  = elem_ops[e][k];
          val = (op == 1 || op == 3) ? '1 : '0;
          exp_we[idx]   = (op < 2);
          exp_addr[idx] = AW'(a);
          exp_din[idx]  = val;
          if (op < 2) mm[a] = val;
          else begin
            obs = fault_rd(AW'(a), mm[a]);
            if (obs !== val) begin
              if (m_cnt < 255) m_cnt++;
              if (!m_fail) begin
                m_fail = 1; m_addr = AW'(a); m_bits = obs ^ val;
              end
            end
          end
          idx++;
        end
      end
  endtask

  function automatic logic [63:0] all_outs();
    return {9'd0, en, men, wen, ren, addr, din, bm, busy, done, fail, fail_addr, fail_bits, err_cnt};
  endfunction

  // ---------------- One run, monitored cycle by cycle ----------------------
  // rst_at > 0 asserts reset so that it is sampled at that edge of the run.
  task automatic run_once(input string nm, input bit hold, input int rst_at);
    int cmd_err = 0, n_men = 0, n_wen = 0, n_ren = 0, n_both = 0, n_bm = 0;
    int done_cyc = -1;
    logic [AW-1:0] a1280 = '0, a1281 = '0;
    bit we1280 = 0, re1281 = 0;
    build_model();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= NCMD + 40; c++) begin
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_rst_outs"}, all_outs(), 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk({nm, "_rst_idle"}, all_outs(), 64'd0);
        return;
      end
      @(posedge clk); #1;
      if (men) begin
        n_men++;
        if (bm !== '1) n_bm++;
      end
      if (men && wen) n_wen++;
      if (men && ren) n_ren++;
      if (wen && ren) n_both++;
      if (c == 1280) begin we1280 = wen; a1280 = addr; end
      if (c == 1281) begin re1281 = ren; a1281 = addr; end
      if (c <= NCMD) begin
        if (men !== 1'b1 || en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            wen !== exp_we[c-1] || ren !== !exp_we[c-1] || addr !== exp_addr[c-1] ||
            (exp_we[c-1] && din !== exp_din[c-1]))
          cmd_err++;
      end else if (done === 1'b1) begin
        done_cyc = c;
        break;
      end else if (men !== 1'b0 || en !== 1'b1 || busy !== 1'b1) begin
        cmd_err++;
      end
    end
    chk({nm, "_cmd_seq"}, cmd_err, 0);
    chk({nm, "_done_edge"}, done_cyc, NCMD + 3);
    chk({nm, "_men_cnt"}, n_men, NCMD);
    chk({nm, "_wen_cnt"}, n_wen, NCMD / 2);
    chk({nm, "_ren_cnt"}, n_ren, NCMD / 2);
    chk({nm, "_wen_and_ren"}, n_both, 0);
    chk({nm, "_bm_ones"}, n_bm, 0);
    chk({nm, "_m2m3_seam"}, {we1280, a1280, re1281, a1281}, {1'b1, 8'hFF, 1'b1, 8'hFF});
    chk({nm, "_done_state"}, {en, busy, done}, 3'b001);
    chk({nm, "_fail"}, fail, m_fail);
    chk({nm, "_fail_addr"}, fail_addr, m_addr);
    chk({nm, "_fail_bits"}, fail_bits, m_bits);
    chk({nm, "_err_cnt"}, err_cnt, m_cnt);
    if (hold) begin
      // start still high in DONE: relaunch on the next edge, results cleared
      @(posedge clk); #1;
      chk({nm, "_relaunch"}, {busy, done, en, fail, err_cnt}, {3'b101, 1'b0, 8'd0});
      @(posedge clk); #1;
      chk({nm, "_relaunch_cmd"}, {men, wen, ren, addr}, {3'b110, 8'h00});
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_abort_outs"}, all_outs(), 64'd0);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_outs", all_outs(), 64'd0);

    f_type = 0;
    run_once("clean", 1'b0, 0);
    chk("clean_spec", {fail, err_cnt}, 9'd0);

    f_type = 1; f_addr = 8'h5A; f_mask = 8'h08;
    run_once("sa1", 1'b0, 0);
    chk("sa1_spec", {fail, fail_addr, fail_bits, err_cnt}, {1'b1, 8'h5A, 8'h08, 8'd3});

    f_type = 2; f_addr = 8'hFF; f_mask = 8'h01;
    run_once("sa0", 1'b0, 0);
    chk("sa0_spec", {fail, fail_addr, fail_bits, err_cnt}, {1'b1, 8'hFF, 8'h01, 8'd2});

    f_type = 3;
    run_once("corrupt", 1'b0, 0);
    chk("corrupt_spec", {fail, fail_addr, err_cnt}, {1'b1, 8'h00, 8'd255});

    f_type = 1; f_addr = 8'h33; f_mask = 8'h80;
    run_once("midreset", 1'b0, 1000);
    f_type = 0;
    run_once("after_rst", 1'b0, 0);

    for (int r = 0; r < 3; r++) begin
      f_type = $urandom_range(1, 2);
      f_addr = AW'($urandom_range(0, DEPTH - 1));
      f_mask = DW'(1) << $urandom_range(0, DW - 1);
      repeat ($urandom_range(1, 6)) @(posedge clk);
      run_once($sformatf("rand%0d", r), 1'b0, 0);
    end

    f_type = 0;
    run_once("hold", 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_march_bist_ctrl.md
Name: sram_march_bist_ctrl

Overview:
- Self-contained March C- BIST engine that drives the dedicated BIST port of a single-port SRAM macro with BIST mux and bit mask (default geometry 256x8).
- Generates MEN/WEN/REN/ADDR/DIN/BM sequences, compares read data on A_DOUT against the expected background, and reports pass/fail, first-failure address/bits and an error count.
- Sits directly upstream of the macro's A_BIST_* pins, in the A_BIST_CLK domain.

Parameters:
- P_ADDR_WIDTH, 8, SRAM address width; depth = 2**P_ADDR_WIDTH.
- P_DATA_WIDTH, 8, SRAM data / bit-mask width.
- P_RD_LAT, 1, macro read latency in clocks; read data is valid P_RD_LAT edges after the edge that samples REN.

Ports:
- A_BIST_CLK  in  1  Sole clock; same clock as the macro BIST port.
- A_BIST_RST  in  1  Reset; synchronous, active-high.
- start  in  1  Level. Sampled only in IDLE/DONE; 1 launches a run.
- A_DOUT  in  P_DATA_WIDTH  Macro read data.
- A_BIST_EN  out  1  Selects the BIST port in the macro; 1 only in RUN and DRAIN.
- A_BIST_MEN  out  1  Memory enable; 1 on every issued operation.
- A_BIST_WEN  out  1  Write enable.
- A_BIST_REN  out  1  Read enable.
- A_BIST_ADDR  out  P_ADDR_WIDTH  Operation address.
- A_BIST_DIN  out  P_DATA_WIDTH  Write data: all-0 or all-1 background.
- A_BIST_BM  out  P_DATA_WIDTH  Bit mask; constant all-1 whenever MEN=1.
- busy  out  1  1 in RUN and DRAIN.
- done  out  1  1 in DONE.
- fail  out  1  Sticky; 1 if any compare has mismatched in the current/last run.
- fail_addr  out  P_ADDR_WIDTH  Address of the first mismatch.
- fail_bits  out  P_DATA_WIDTH  A_DOUT XOR expected at the first mismatch.
- err_cnt  out  8  Mismatching reads; saturates at 255.

Behaviour:
- All outputs are registered. Reset (any state) returns to IDLE. Reset values: every output = 0, including EN, MEN, WEN, REN, ADDR, DIN, BM, done, fail, fail_addr, fail_bits and err_cnt. The compare pipeline is flushed.
- States:
  - IDLE: start=1 -> RUN. Clears fail, fail_addr, fail_bits and err_cnt; element=M0; addr=0.
  - RUN: issues one operation per clock, with no idle cycles between operations or elements.
  - DRAIN: drives MEN=WEN=REN=0 and EN=1 for P_RD_LAT+1 cycles while outstanding compares retire, then -> DONE.
  - DONE: done=1, EN=0. start=1 -> RUN, with the same clearing as from IDLE.
- Elements, in order (D0=0x00, D1=0xFF):
  - M0: up, w0.
  - M1: up, r0 then w1.
  - M2: up, r1 then w0.
  - M3: down, r0 then w1.
  - M4: down, r1 then w0.
  - M5: down, r0.
- Direction and ops per address:
  - "up" runs addr 0..max; "down" runs max..0.
  - Two-op elements issue the read at cycle t and the write at t+1, at the same address.
  - Total commands = 10 x depth (2560 at default).
- Transitions:
  - The element advances after the last op at the terminal address.
  - The next element starts at its own start address (0 for up, max for down) on the next cycle.
  - After M5 at addr 0 -> DRAIN.
  - The address counter wraps at the terminal address and never exceeds max.
- Per-op encoding: MEN=1; WEN=1 for writes and REN=1 for reads, never both; DIN=D0 or D1 for writes, don't-care but held at the last value for reads; BM=all-1.
- Compare:
  - A read command registered at edge k is sampled by the macro at k+1; its data is compared at edge k+1+P_RD_LAT.
  - A shift pipeline of depth P_RD_LAT+1 carries {valid, addr, expected}.
  - On a mismatch: err_cnt increments (saturating); if fail was 0, fail_addr and fail_bits are captured and fail set. Later mismatches never overwrite the capture.
- start=1 while in RUN or DRAIN is ignored. start held high in DONE immediately relaunches a run, so start is treated as a level.
- Reset mid-run: on the next edge MEN=EN=0, no further operations are issued and results are cleared.

Test Plan:
- Fault-free model, start pulsed at edge 0:
  - first command (w0 @0x00) registered at edge 1; last (r0 @0x00) at edge 2560;
  - done=1 from edge 2563; fail=0; err_cnt=0;
  - exactly 2560 cycles with MEN=1 (1280 WEN, 1280 REN).
- Stuck-at-1 on bit 3 at 0x5A -> fail=1, fail_addr=0x5A, fail_bits=0x08, err_cnt=3 (the r0 reads in M1, M3 and M5).
- Stuck-at-0 on bit 0 at 0xFF -> first failure in M2 r1: fail_addr=0xFF, fail_bits=0x01, err_cnt=2.
- Corrupt all read data in every cycle -> err_cnt saturates at 255; fail_addr=0x00 (first read of M1).
- Sequencing checks:
  - M2->M3 boundary: w0@0xFF is immediately followed by r0@0xFF, with no gap.
  - WEN&REN is never 1; BM=0xFF whenever MEN=1.
- Reset and start handling:
  - Assert A_BIST_RST at edge 1000 -> next cycle all outputs 0, state IDLE.
  - Re-start -> a full clean run as in the first scenario.
  - start held high throughout a run -> no restart until DONE.
